// File: rtl/mem_stage_ctrl.sv
// MEM-stage controller: sequences loads/stores on a req/ack data bus, freezes
// upstream stages while an access is pending and drives the MEM/WB register.
module mem_stage_ctrl #(
  parameter int unsigned TIMEOUT_CYC = 255,
  parameter int unsigned CNT_W       = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] AluRes_i,
  input  logic [31:0] WrData_i,
  input  logic        MemRd_i,
  input  logic        MemWr_i,
  input  logic [1:0]  MemtoReg_i,
  input  logic        RegWr_i,
  input  logic [4:0]  WrReg_i,
  input  logic [31:0] PC4_i,
  output logic        stall_o,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  input  logic        bus_ack,
  input  logic [31:0] bus_rdata,
  output logic [31:0] WbData_o,
  output logic        RegWr_o,
  output logic [4:0]  WrReg_o,
  output logic        align_err_o,
  output logic        bus_err_o
);

  typedef enum logic {IDLE, BUSY} state_e;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              req_q, req_d, we_q, we_d;
  logic [31:0]       addr_q, addr_d, wdata_q, wdata_d;
  logic [31:0]       wb_q, wb_d;
  logic              regwr_q, regwr_d;
  logic [4:0]        wrreg_q, wrreg_d;
  logic              aerr_q, aerr_d, berr_q, berr_d;
  logic              memop, misal, wb_load;
  logic [31:0]       wb_sel;

  assign memop = MemRd_i | MemWr_i;
  assign misal = memop & (AluRes_i[1:0] != 2'b00);

  always_comb begin
    unique case (MemtoReg_i)
      2'b01:   wb_sel = bus_rdata;
      2'b10:   wb_sel = PC4_i;
      default: wb_sel = AluRes_i;
    endcase
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    req_d   = req_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    aerr_d  = 1'b0;
    berr_d  = 1'b0;
    wb_load = 1'b0;
    stall_o = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (memop && !misal) begin
          // MemWr_i wins when both are set, so a dual request becomes a store
          stall_o = 1'b1;
          state_d = BUSY;
          req_d   = 1'b1;
          we_d    = MemWr_i;
          addr_d  = {AluRes_i[31:2], 2'b00};
          wdata_d = WrData_i;
          cnt_d   = '0;
        end else if (misal) begin
          aerr_d = 1'b1;
        end else begin
          wb_load = 1'b1;
        end
      end
      BUSY: begin
        if (bus_ack) begin
          state_d = IDLE;
          req_d   = 1'b0;
          wb_load = 1'b1;
        end else if (cnt_q == CNT_LAST) begin
          state_d = IDLE;
          req_d   = 1'b0;
          berr_d  = 1'b1;
        end else begin
          stall_o = 1'b1;
          cnt_d   = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    wb_d    = wb_load ? wb_sel : '0;
    regwr_d = wb_load & RegWr_i;
    wrreg_d = wb_load ? WrReg_i : '0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      wb_q    <= '0;
      regwr_q <= 1'b0;
      wrreg_q <= '0;
      aerr_q  <= 1'b0;
      berr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      req_q   <= req_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      wb_q    <= wb_d;
      regwr_q <= regwr_d;
      wrreg_q <= wrreg_d;
      aerr_q  <= aerr_d;
      berr_q  <= berr_d;
    end
  end

  assign bus_req     = req_q;
  assign bus_we      = we_q;
  assign bus_addr    = addr_q;
  assign bus_wdata   = wdata_q;
  assign WbData_o    = wb_q;
  assign RegWr_o     = regwr_q;
  assign WrReg_o     = wrreg_q;
  assign align_err_o = aerr_q;
  assign bus_err_o   = berr_q;

endmodule
